// File: rtl/voice_mixer_if.sv
`default_nettype none
// ============================================================================
//  Module      : voice_mixer_if
//  Description : Bundle of the voice_mixer control, voice and mix signals.
//                master = driver of voices/controls (voice bank side),
//                slave  = the mixer itself.
//  Signals     : sample_tick, voice_in, gain, pan, mute, clr_overrun  (to mixer)
//                ldata, rdata, out_valid, busy, overrun             (from mixer)
//  Revision    : 1.0  initial release
// ============================================================================
interface voice_mixer_if #(
    parameter int NUM_VOICES = 8,
    parameter int W          = 16
);
    logic                         sample_tick;
    logic [NUM_VOICES*W-1:0]      voice_in;
    logic [NUM_VOICES*16-1:0]     gain;
    logic [NUM_VOICES*16-1:0]     pan;
    logic [NUM_VOICES-1:0]        mute;
    logic                         clr_overrun;
    logic signed [W-1:0]          ldata;
    logic signed [W-1:0]          rdata;
    logic                         out_valid;
    logic                         busy;
    logic                         overrun;

    modport master (
        output sample_tick, voice_in, gain, pan, mute, clr_overrun,
        input  ldata, rdata, out_valid, busy, overrun
    );

    modport slave (
        input  sample_tick, voice_in, gain, pan, mute, clr_overrun,
        output ldata, rdata, out_valid, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/voice_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : voice_mixer
//  Description : Time-multiplexed N-voice stereo mixer. On sample_tick the
//                voice samples and per-voice gain/pan/mute are snapshotted,
//                one voice is scaled/panned and accumulated per clock, and
//                the saturated stereo mix is presented with a one-cycle
//                out_valid pulse N+1 cycles after the tick.
//  Ports       : Clk, Reset (async, active-high)
//                bus (voice_mixer_if.slave): sample_tick, voice_in, gain,
//                pan, mute, clr_overrun -> ldata, rdata, out_valid, busy,
//                overrun
//  Revision    : 1.0  initial release
// ============================================================================
module voice_mixer #(
    parameter int NUM_VOICES = 8,
    parameter int W          = 16
) (
    input  wire logic     Clk,
    input  wire logic     Reset,
    voice_mixer_if.slave  bus
);
    localparam int c_idx_w = $clog2(NUM_VOICES);
    localparam int c_acc_w = W + $clog2(NUM_VOICES) + 1;
    localparam logic signed [c_acc_w-1:0] c_sat_max = c_acc_w'((64'sd1 <<< (W-1)) - 64'sd1);
    localparam logic signed [c_acc_w-1:0] c_sat_min = c_acc_w'(-(64'sd1 <<< (W-1)));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_SAT   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Snapshot registers; gain/pan are stored already clamped to 15 bits
    logic [NUM_VOICES*W-1:0]      r_voice;
    logic [NUM_VOICES*15-1:0]     r_gain;
    logic [NUM_VOICES*15-1:0]     r_pan;
    logic [NUM_VOICES-1:0]        r_mute;
    logic [NUM_VOICES*15-1:0]     w_gain_clamp;
    logic [NUM_VOICES*15-1:0]     w_pan_clamp;

    logic [c_idx_w-1:0]           r_index;
    logic signed [c_acc_w-1:0]    r_accl;
    logic signed [c_acc_w-1:0]    r_accr;
    logic signed [W-1:0]          r_ldata;
    logic signed [W-1:0]          r_rdata;
    logic                         r_out_valid;
    logic                         r_overrun;

    // Any value with bit 15 set saturates to 0x7FFF
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_clamp
        assign w_gain_clamp[gi*15 +: 15] = bus.gain[gi*16+15] ? 15'h7FFF : bus.gain[gi*16 +: 15];
        assign w_pan_clamp[gi*15 +: 15]  = bus.pan[gi*16+15]  ? 15'h7FFF : bus.pan[gi*16 +: 15];
    end

    // Per-voice datapath for the channel selected by r_index
    logic signed [W-1:0]          w_v;
    logic [14:0]                  w_g;
    logic [14:0]                  w_p;
    logic [14:0]                  w_pinv;
    logic signed [W+15:0]         w_prod_full;
    logic signed [W-1:0]          w_prod;
    logic signed [W+15:0]         w_pl_full;
    logic signed [W+15:0]         w_pr_full;
    logic signed [W-1:0]          w_pl;
    logic signed [W-1:0]          w_pr;
    logic signed [c_acc_w-1:0]    w_accl_next;
    logic signed [c_acc_w-1:0]    w_accr_next;
    logic                         w_last;

    assign w_v    = r_voice[r_index*W +: W];
    assign w_g    = r_gain[r_index*15 +: 15];
    assign w_p    = r_pan[r_index*15 +: 15];
    assign w_pinv = 15'h7FFF - w_p;

    // Gain <= 0x7FFF guarantees the shifted products fit back into W bits
    assign w_prod_full = $signed(w_v) * $signed({1'b0, w_g});
    assign w_prod      = W'(w_prod_full >>> 15);
    assign w_pl_full   = w_prod * $signed({1'b0, w_pinv});
    assign w_pr_full   = w_prod * $signed({1'b0, w_p});
    assign w_pl        = r_mute[r_index] ? '0 : W'(w_pl_full >>> 15);
    assign w_pr        = r_mute[r_index] ? '0 : W'(w_pr_full >>> 15);

    assign w_accl_next = r_accl + c_acc_w'(w_pl);
    assign w_accr_next = r_accr + c_acc_w'(w_pr);
    assign w_last      = (r_state == S_ACCUM) && (r_index == c_idx_w'(NUM_VOICES - 1));

    function automatic logic signed [W-1:0] sat_w(input logic signed [c_acc_w-1:0] a);
        if (a > c_sat_max)
            return W'(c_sat_max);
        else if (a < c_sat_min)
            return W'(c_sat_min);
        else
            return W'(a);
    endfunction

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.sample_tick) w_state_next = S_ACCUM;
            S_ACCUM: if (w_last)          w_state_next = S_SAT;
            S_SAT:                        w_state_next = S_IDLE;
            default:                      w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_voice     <= '0;
            r_gain      <= '0;
            r_pan       <= '0;
            r_mute      <= '0;
            r_index     <= '0;
            r_accl      <= '0;
            r_accr      <= '0;
            r_ldata     <= '0;
            r_rdata     <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;

            if (r_state == S_IDLE && bus.sample_tick) begin
                r_voice <= bus.voice_in;
                r_gain  <= w_gain_clamp;
                r_pan   <= w_pan_clamp;
                r_mute  <= bus.mute;
                r_index <= '0;
                r_accl  <= '0;
                r_accr  <= '0;
            end

            if (r_state == S_ACCUM) begin
                r_accl <= w_accl_next;
                r_accr <= w_accr_next;
                if (w_last) begin
                    // Result is registered from the final sum so that
                    // out_valid and data appear together in the SAT cycle
                    r_ldata     <= sat_w(w_accl_next);
                    r_rdata     <= sat_w(w_accr_next);
                    r_out_valid <= 1'b1;
                end else begin
                    r_index <= r_index + c_idx_w'(1);
                end
            end

            // Set has priority over clear
            if (bus.sample_tick && r_state != S_IDLE)
                r_overrun <= 1'b1;
            else if (bus.clr_overrun)
                r_overrun <= 1'b0;
        end
    end

    assign bus.ldata     = r_ldata;
    assign bus.rdata     = r_rdata;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.overrun   = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_voice_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_voice_mixer
//  Description : Self-checking bench for voice_mixer (N=8, W=16). Expected
//                mixes come from an arithmetic reference model of the
//                gain/pan/mute/saturation rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_voice_mixer;
    localparam int N = 8;
    localparam int W = 16;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    voice_mixer_if #(.NUM_VOICES(N), .W(W)) bus();
    voice_mixer #(.NUM_VOICES(N), .W(W)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    int      total = 0;
    int      bad   = 0;
    longint  v[N];
    longint  g[N];
    longint  p[N];
    bit      m[N];
    longint  exp_l;
    longint  exp_r;
    bit      exp_ov;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // floor(a / 32768) for either sign
    function automatic longint fdiv(input longint a);
        return (a >= 0) ? a / 32768 : -((-a + 32767) / 32768);
    endfunction

    function automatic longint clamp15(input longint x);
        return (x >= 32768) ? 32767 : x;
    endfunction

    function automatic longint sat16(input longint x);
        return (x > 32767) ? 32767 : ((x < -32768) ? -32768 : x);
    endfunction

    task automatic model();
        longint sl, sr, prod, gg, pp;
        sl = 0;
        sr = 0;
        for (int i = 0; i < N; i++) begin
            gg   = clamp15(g[i]);
            pp   = clamp15(p[i]);
            prod = fdiv(v[i] * gg);
            if (!m[i]) begin
                sl += fdiv(prod * (32767 - pp));
                sr += fdiv(prod * pp);
            end
        end
        exp_l = sat16(sl);
        exp_r = sat16(sr);
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            bus.voice_in[i*W +: W] = 16'(v[i]);
            bus.gain[i*16 +: 16]   = 16'(g[i]);
            bus.pan[i*16 +: 16]    = 16'(p[i]);
            bus.mute[i]            = m[i];
        end
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < N; i++) begin
            bus.voice_in[i*W +: W] = 16'($urandom);
            bus.gain[i*16 +: 16]   = 16'($urandom);
            bus.pan[i*16 +: 16]    = 16'($urandom);
        end
        bus.mute = N'($urandom);
    endtask

    task automatic set_all(input longint vv, input longint gg, input longint pp, input bit mm);
        for (int i = 0; i < N; i++) begin
            v[i] = vv;
            g[i] = gg;
            p[i] = pp;
            m[i] = mm;
        end
    endtask

    // Tick in the current cycle t; follow through t+N+2. ov_at > 0 adds a
    // second tick at t+ov_at. Inputs are scrambled right after the snapshot.
    task automatic run_mix(input string tag, input int ov_at);
        apply_inputs();
        model();
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        scramble_inputs();
        for (int c = 1; c <= N + 1; c++) begin
            bus.sample_tick = (c == ov_at);
            check($sformatf("%s_busy_c%0d", tag, c), bus.busy, 1);
            check($sformatf("%s_valid_c%0d", tag, c), bus.out_valid, (c == N + 1));
            check($sformatf("%s_ovr_c%0d", tag, c), bus.overrun, exp_ov);
            if (c == ov_at) exp_ov = 1'b1;
            if (c == N + 1) begin
                check({tag, "_ldata"}, bus.ldata, exp_l);
                check({tag, "_rdata"}, bus.rdata, exp_r);
            end
            step();
        end
        bus.sample_tick = 1'b0;
        check({tag, "_idle_busy"}, bus.busy, 0);
        check({tag, "_idle_valid"}, bus.out_valid, 0);
        check({tag, "_hold_ldata"}, bus.ldata, exp_l);
        check({tag, "_hold_ovr"}, bus.overrun, exp_ov);
    endtask

    initial begin
        Reset           = 1'b1;
        bus.sample_tick = 1'b0;
        bus.clr_overrun = 1'b0;
        bus.voice_in    = '0;
        bus.gain        = '0;
        bus.pan         = '0;
        bus.mute        = '0;
        exp_ov          = 1'b0;
        step();
        step();
        step();
        Reset = 1'b0;

        // 1. Idle after reset
        for (int i = 0; i < 5; i++) step();
        check("rst_ldata", bus.ldata, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_ovr", bus.overrun, 0);

        // 2. Single voice, centre pan
        set_all(0, 16'h7FFF, 16'h4000, 1'b1);
        v[0] = 16384;
        m[0] = 1'b0;
        run_mix("center", 0);
        check("center_l_const", bus.ldata, 8191);
        check("center_r_const", bus.rdata, 8191);

        // 3. Positive and negative saturation (back-to-back ticks)
        set_all(32767, 16'h7FFF, 0, 1'b0);
        run_mix("satpos", 0);
        check("satpos_l_const", bus.ldata, 32767);
        check("satpos_r_const", bus.rdata, 0);
        set_all(-32768, 16'h7FFF, 16'h7FFF, 1'b0);
        run_mix("satneg", 0);
        check("satneg_l_const", bus.ldata, 0);
        check("satneg_r_const", bus.rdata, -32768);

        // 4. Gain/pan clamping
        set_all(0, 16'hFFFF, 16'hFFFF, 1'b1);
        v[0] = 16384;
        m[0] = 1'b0;
        run_mix("clamp", 0);
        check("clamp_l_const", bus.ldata, 0);
        check("clamp_r_const", bus.rdata, 16382);

        // 5. Overrun: second tick at t+3, then clear
        set_all(1000, 16'h6000, 16'h2000, 1'b0);
        v[3] = -20000;
        run_mix("ovr", 3);
        bus.clr_overrun = 1'b1;
        step();
        bus.clr_overrun = 1'b0;
        exp_ov = 1'b0;
        check("ovr_cleared", bus.overrun, 0);

        // Set beats clear in the same cycle
        apply_inputs();
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        step();
        bus.sample_tick = 1'b1;
        bus.clr_overrun = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        bus.clr_overrun = 1'b0;
        check("ovr_set_wins", bus.overrun, 1);
        for (int i = 0; i < N + 2; i++) step();
        check("ovr_mix_done", bus.busy, 0);
        bus.clr_overrun = 1'b1;
        step();
        bus.clr_overrun = 1'b0;
        check("ovr_cleared2", bus.overrun, 0);

        // 6. Reset in the middle of a mix
        set_all(5000, 16'h7FFF, 16'h1000, 1'b0);
        apply_inputs();
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        step();
        step();
        step();
        Reset = 1'b1;
        #1;
        check("midrst_ldata", bus.ldata, 0);
        check("midrst_rdata", bus.rdata, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_valid", bus.out_valid, 0);
        step();
        Reset = 1'b0;
        for (int i = 0; i < N + 3; i++) begin
            check($sformatf("midrst_novalid_%0d", i), bus.out_valid, 0);
            step();
        end
        run_mix("postrst", 0);

        // 7. Randomized mixes
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < N; i++) begin
                v[i] = longint'($signed(16'($urandom)));
                g[i] = longint'($urandom_range(0, 65535));
                p[i] = longint'($urandom_range(0, 65535));
                m[i] = ($urandom_range(0, 3) == 0);
            end
            run_mix($sformatf("rand%0d", k), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
